// File: rtl/sprite_mover.sv
// Frame-tick driven sprite animator: erase, step diagonally with wall bounce, redraw.
// Optional build macro SPRITE_MOVER_PENDING_EN keeps one tick that arrives while busy.
module sprite_mover #(
    parameter int         SIZE  = 4,
    parameter int         X_MAX = 160,
    parameter int         Y_MAX = 120,
    parameter logic [2:0] FG    = 3'b111,
    parameter logic [2:0] BG    = 3'b000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [24:0] frame_count,
    input  logic        enable,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ERASE, MOVE, DRAW} state_t;

    localparam logic [2:0] LAST  = 3'(SIZE - 1);
    localparam logic [7:0] X_LIM = 8'(X_MAX - SIZE);
    localparam logic [6:0] Y_LIM = 7'(Y_MAX - SIZE);

    state_t      state_q, state_d;
    logic [7:0]  px_q, px_d;
    logic [6:0]  py_q, py_d;
    logic        dx_q, dx_d, dy_q, dy_d;
    logic [2:0]  ox_q, ox_d, oy_q, oy_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic        plot_q, plot_d;
    logic        busy_q, busy_d;
`ifdef SPRITE_MOVER_PENDING_EN
    logic        pend_q, pend_d;
`endif

    logic        tick, start, last_pix;
    logic [2:0]  ox_n, oy_n;

    assign tick     = (frame_count == 25'd0) && enable;
    assign last_pix = (ox_q == LAST) && (oy_q == LAST);
    assign ox_n     = (ox_q == LAST) ? 3'd0 : ox_q + 3'd1;
    assign oy_n     = (ox_q == LAST) ? oy_q + 3'd1 : oy_q;

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d  = state_q;
        px_d     = px_q;
        py_d     = py_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
`ifdef SPRITE_MOVER_PENDING_EN
        pend_d = pend_q;
        start  = tick || (pend_q && enable);
        if (!enable) begin
            pend_d = 1'b0;
        end else if (state_q != IDLE && tick) begin
            pend_d = 1'b1;
        end else if (state_q == IDLE && start) begin
            pend_d = 1'b0;
        end
`else
        start = tick;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ERASE;
                    ox_d     = 3'd0;
                    oy_d     = 3'd0;
                    x_d      = px_q;
                    y_d      = py_q;
                    colour_d = BG;
                    plot_d   = 1'b1;
                end
            end
            ERASE, DRAW: begin
                if (last_pix) begin
                    state_d = (state_q == ERASE) ? MOVE : IDLE;
                    ox_d    = 3'd0;
                    oy_d    = 3'd0;
                end else begin
                    ox_d     = ox_n;
                    oy_d     = oy_n;
                    x_d      = px_q + {5'd0, ox_n};
                    y_d      = py_q + {4'd0, oy_n};
                    colour_d = (state_q == ERASE) ? BG : FG;
                    plot_d   = 1'b1;
                end
            end
            MOVE: begin
                // Reverse at a wall and step one pixel back inside in the same cycle.
                if (dx_q && px_q == X_LIM) begin
                    dx_d = 1'b0;
                    px_d = px_q - 8'd1;
                end else if (!dx_q && px_q == 8'd0) begin
                    dx_d = 1'b1;
                    px_d = px_q + 8'd1;
                end else begin
                    px_d = dx_q ? px_q + 8'd1 : px_q - 8'd1;
                end
                if (dy_q && py_q == Y_LIM) begin
                    dy_d = 1'b0;
                    py_d = py_q - 7'd1;
                end else if (!dy_q && py_q == 7'd0) begin
                    dy_d = 1'b1;
                    py_d = py_q + 7'd1;
                end else begin
                    py_d = dy_q ? py_q + 7'd1 : py_q - 7'd1;
                end
                state_d  = DRAW;
                x_d      = px_d;
                y_d      = py_d;
                colour_d = FG;
                plot_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= IDLE;
            px_q     <= 8'd0;
            py_q     <= 7'd0;
            dx_q     <= 1'b1;
            dy_q     <= 1'b1;
            ox_q     <= 3'd0;
            oy_q     <= 3'd0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= BG;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SPRITE_MOVER_PENDING_EN
            pend_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            px_q     <= px_d;
            py_q     <= py_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
`ifdef SPRITE_MOVER_PENDING_EN
            pend_q   <= pend_d;
`endif
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: randomized ticks and input noise checked cycle by cycle against
// a position/velocity model of the bouncing sprite (handles SPRITE_MOVER_PENDING_EN too).
module tb_sprite_mover;

    localparam int         SIZE  = 4;
    localparam int         X_MAX = 160;
    localparam int         Y_MAX = 120;
    localparam logic [2:0] FG    = 3'b111;
    localparam logic [2:0] BG    = 3'b000;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [24:0] frame_count = 25'd0;
    logic        enable = 1'b1;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model: sprite corner and velocity in plain integers.
    int mpx, mpy, mdx, mdy;
    bit pend;
    int seq_count = 0;
    int first_draw_x, first_draw_y;

    sprite_mover #(.SIZE(SIZE), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .FG(FG), .BG(BG)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .frame_count(frame_count),
        .enable     (enable),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input bit exp_plot, input int ex, input int ey,
                             input logic [2:0] ec, input bit exp_busy);
        check({tag, ".plot"}, 32'(plot), 32'(exp_plot));
        check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
        if (exp_plot) begin
            check({tag, ".x"}, 32'(x), ex);
            check({tag, ".y"}, 32'(y), ey);
            check({tag, ".colour"}, 32'(colour), 32'(ec));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_out(tag, 1'b0, 0, 0, BG, 1'b0);
        check({tag, ".x"}, 32'(x), 0);
        check({tag, ".y"}, 32'(y), 0);
        check({tag, ".colour"}, 32'(colour), 32'(BG));
    endtask

    function automatic void model_reset();
        mpx  = 0;
        mpy  = 0;
        mdx  = 1;
        mdy  = 1;
        pend = 1'b0;
    endfunction

    // Reflect the velocity whenever the next step would push the sprite off screen.
    function automatic void model_move();
        if (mpx + mdx < 0 || mpx + mdx + SIZE > X_MAX) mdx = -mdx;
        mpx += mdx;
        if (mpy + mdy < 0 || mpy + mdy + SIZE > Y_MAX) mdy = -mdy;
        mpy += mdy;
    endfunction

    task automatic drive_noise(input int k, input bit noise, input int inject_at);
        if (noise) begin
            if ($urandom_range(0, 3) == 0) frame_count = 25'd0;
            else frame_count = 25'($urandom_range(1, 25'h1ff_ffff));
            enable = 1'($urandom_range(0, 1));
        end else begin
            frame_count = 25'($urandom_range(1, 1000));
            enable = 1'b1;
            if (k == inject_at) frame_count = 25'd0;
        end
`ifdef SPRITE_MOVER_PENDING_EN
        if (!enable) pend = 1'b0;
        else if (frame_count == 25'd0) pend = 1'b1;
`endif
    endtask

    // Called with the first ERASE pixel already presented.
    task automatic run_seq(input bit noise, input int inject_at, input int abort_at,
                           output bit aborted);
        int k = 0;
        aborted = 1'b0;
        seq_count++;
        for (int oy = 0; oy < SIZE; oy++) begin
            for (int ox = 0; ox < SIZE; ox++) begin
                check_out("erase", 1'b1, mpx + ox, mpy + oy, BG, 1'b1);
                drive_noise(k++, noise, inject_at);
                step();
            end
        end
        check_out("move", 1'b0, 0, 0, BG, 1'b1);
        model_move();
        drive_noise(k++, noise, inject_at);
        step();
        for (int oy = 0; oy < SIZE; oy++) begin
            for (int ox = 0; ox < SIZE; ox++) begin
                if (oy == 0 && ox == 0) begin
                    first_draw_x = int'(x);
                    first_draw_y = int'(y);
                    if (seq_count == 116) begin
                        check("bounce116.x", 32'(x), 116);
                        check("bounce116.y", 32'(y), 116);
                    end
                    if (seq_count == 117) begin
                        check("bounce117.x", 32'(x), 117);
                        check("bounce117.y", 32'(y), 115);
                    end
                    if (seq_count == 157) begin
                        check("bounce157.x", 32'(x), 155);
                        check("bounce157.y", 32'(y), 75);
                    end
                end
                check_out("draw", 1'b1, mpx + ox, mpy + oy, FG, 1'b1);
                if (oy * SIZE + ox == abort_at) begin
                    resetn = 1'b0;
                    step();
                    check_reset_outputs("abort");
                    model_reset();
                    resetn = 1'b1;
                    frame_count = 25'd7;
                    enable = 1'b1;
                    aborted = 1'b1;
                    return;
                end
                drive_noise(k++, noise, inject_at);
                step();
            end
        end
        check_out("idle", 1'b0, 0, 0, BG, 1'b0);
    endtask

    task automatic after_seq();
`ifdef SPRITE_MOVER_PENDING_EN
        bit ab;
        while (pend) begin
            frame_count = 25'd5;
            enable = 1'b1;
            pend = 1'b0;
            step();
            run_seq(1'b0, -1, -1, ab);
        end
`endif
    endtask

    task automatic tick_and_run(input bit noise, input int inject_at, input int abort_at);
        bit ab;
        frame_count = 25'd0;
        enable = 1'b1;
        step();
        run_seq(noise, inject_at, abort_at, ab);
        if (!ab) after_seq();
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                frame_count = 25'($urandom_range(1, 25'h1ff_ffff));
                enable = 1'($urandom_range(0, 1));
            end else begin
                frame_count = 25'd0;
                enable = 1'b0;
            end
            step();
            check_out("gap", 1'b0, 0, 0, BG, 1'b0);
        end
    endtask

    initial begin
        // Reset held with a live tick on the inputs: reset must win.
        resetn = 1'b0;
        frame_count = 25'd0;
        enable = 1'b1;
        model_reset();
        repeat (3) begin
            step();
            check_reset_outputs("reset");
        end
        resetn = 1'b1;
        frame_count = 25'd1234;
        idle_gap(4);

        frame_count = 25'd0;
        enable = 1'b0;
        repeat (5) begin
            step();
            check_out("disabled", 1'b0, 0, 0, BG, 1'b0);
        end

        tick_and_run(1'b0, -1, -1);
        check("first.draw_x", 32'(first_draw_x), 1);
        check("first.draw_y", 32'(first_draw_y), 1);
        idle_gap(2);

        // Second zero mid-sequence: dropped by default, queued with the pending option.
        tick_and_run(1'b0, 10, -1);
        frame_count = 25'd99;
        enable = 1'b1;
        step();
        check_out("after_overlap", 1'b0, 0, 0, BG, 1'b0);

        while (seq_count < 160) begin
            tick_and_run(1'($urandom_range(0, 1)), -1, -1);
            idle_gap($urandom_range(0, 3));
        end

        tick_and_run(1'b0, -1, 5);
        step();
        check_out("post_abort", 1'b0, 0, 0, BG, 1'b0);
        tick_and_run(1'b0, -1, -1);
        check("restart.draw_x", 32'(first_draw_x), 1);
        check("restart.draw_y", 32'(first_draw_y), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
